// File: rtl/multi_clktick_pkg.sv
// Shared types for the multi-channel programmable tick generator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Holds the per-channel mode encoding and the channel FSM state encoding
// used by multi_clktick and clktick_chan.
package multi_clktick_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/clktick_chan.sv
// One tick channel: IDLE/RUN down-counter with active + shadow divisor.
// Latency: tick registered, asserted the edge after the count reaches 0 on a step.
// Backpressure: owner must not write while pending is high (top gates via cfg_ready).
//
// Ports: clk, rst (sync, active-high); step (count enable), start, stop,
// mode (0 periodic / 1 one-shot); wr + wr_n (accepted divisor write);
// tick (1-cycle pulse), busy (state == RUN), pending (shadow not yet applied).
module clktick_chan
    import multi_clktick_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RESET_N = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_n,
    output logic             tick,
    output logic             busy,
    output logic             pending
);

    state_e           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] act_n;
    logic [WIDTH-1:0] shd_n;
    logic             pend;
    logic             tick_r;

    logic [WIDTH-1:0] load_n;
    logic             terminal;
    logic             reload;
    logic             promote;

    // Any load of the counter picks up a waiting shadow value first.
    assign load_n   = pend ? shd_n : act_n;
    assign terminal = (state == ST_RUN) && step && (count == '0);
    // stop beats both start and a same-cycle terminal count.
    assign reload   = !stop && (start || terminal);
    // The shadow also drains on its own once the channel sits idle.
    assign promote  = pend && (reload || (state == ST_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            tick_r <= 1'b0;
            act_n  <= RESET_N;
            shd_n  <= RESET_N;
            pend   <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
            end else if (start) begin
                state <= ST_RUN;
                count <= load_n;
            end else if (terminal) begin
                tick_r <= 1'b1;
                count  <= load_n;
                if (mode == MODE_ONESHOT) begin
                    state <= ST_IDLE;
                end
            end else if ((state == ST_RUN) && step) begin
                count <= count - WIDTH'(1);
            end

            if (promote) begin
                act_n <= shd_n;
                pend  <= 1'b0;
            end
            // A write only arrives while pend is clear, so it never races a
            // promotion; a same-cycle reload above has already used act_n.
            if (wr) begin
                shd_n <= wr_n;
                pend  <= 1'b1;
            end
        end
    end

    assign tick    = tick_r;
    assign busy    = (state == ST_RUN);
    assign pending = pend;

endmodule

// File: rtl/multi_clktick.sv
// Multi-channel programmable tick generator with shared optional prescaler.
// Latency: tick is registered; divisor writes take effect at the next reload/start/idle cycle.
// Backpressure: cfg_ready low while the target channel still holds a pending divisor.
//
// Ports: clk, rst (sync, active-high); en (global), ch_en/mode/start/stop per
// channel; cfg_valid/cfg_ch/cfg_n divisor write with cfg_ready; pre_n when the
// prescaler is built in; tick (1-cycle pulses), busy (channel running).
// Optional build macro: MULTI_CLKTICK_PRESCALE_EN adds pre_n and a shared
// prescaler that throttles every channel's step. CHANNELS must be >= 2.
module multi_clktick
    import multi_clktick_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int RESET_N  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [CHANNELS-1:0]         ch_en,
    input  logic [CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]         start,
    input  logic [CHANNELS-1:0]         stop,
    input  logic                        cfg_valid,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]            cfg_n,
`ifdef MULTI_CLKTICK_PRESCALE_EN
    input  logic [WIDTH-1:0]            pre_n,
`endif
    output logic                        cfg_ready,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS-1:0]         busy
);

    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr;
    logic [(1<<CW)-1:0]  pend_ext;
    logic                pre_stb;

    // Unused channel codes read as "not pending", so writes to them are
    // accepted and simply dropped by the decode below.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[CHANNELS-1:0]   = pending;
    end

    assign cfg_ready = !rst && !pend_ext[cfg_ch];

    always_comb begin
        wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == CW'(i));
        end
    end

`ifdef MULTI_CLKTICK_PRESCALE_EN
    logic [WIDTH-1:0] pre_cnt;

    // Strobe on the zero state; the reload makes the strobe period pre_n+1.
    assign pre_stb = (pre_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= pre_stb ? pre_n : (pre_cnt - WIDTH'(1));
        end
    end
`else
    assign pre_stb = 1'b1;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clktick_chan #(
            .WIDTH   (WIDTH),
            .RESET_N (WIDTH'(RESET_N))
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .step    (en && ch_en[g] && pre_stb),
            .start   (start[g]),
            .stop    (stop[g]),
            .mode    (mode[g]),
            .wr      (wr[g]),
            .wr_n    (cfg_n),
            .tick    (tick[g]),
            .busy    (busy[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: doc/multi_clktick.md
MULTI_CLKTICK -- requirements
Module: multi_clktick

Interface
REQ-001 SHALL take parameter WIDTH, default 16, counter and divisor width in bits.
REQ-002 SHALL take parameter CHANNELS, default 4, number of independent tick channels.
REQ-003 SHALL take parameter RESET_N, default 0, divisor loaded into every channel at reset.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  global enable; no channel counts while low.
REQ-007 ch_en  in  CHANNELS  per-channel enable.
REQ-008 mode  in  CHANNELS  per channel: 0 = periodic, 1 = one-shot.
REQ-009 start  in  CHANNELS  per-channel start/restart pulse.
REQ-010 stop  in  CHANNELS  per-channel stop pulse.
REQ-011 cfg_valid  in  1  divisor write request.
REQ-012 cfg_ch  in  $clog2(CHANNELS)  target channel of write.
REQ-013 cfg_n  in  WIDTH  new divisor; channel period = N+1 steps.
REQ-014 cfg_ready  out  1  write accepted this cycle when high with cfg_valid.
REQ-015 tick  out  CHANNELS  per-channel registered single-cycle tick pulse.
REQ-016 busy  out  CHANNELS  channel in RUN state.

Function
REQ-017 Per-channel step SHALL be en & ch_en[i] & pre_stb (pre_stb per Configuration).
REQ-018 Each channel SHALL implement FSM IDLE/RUN; busy[i] = (state == RUN).
REQ-019 IDLE: start[i] -> RUN with count <= active N; tick[i] <= 0.
REQ-020 RUN, step, count != 0: count <= count-1, tick[i] <= 0.
REQ-021 RUN, step, count == 0: tick[i] <= 1 next edge, count <= active N; mode 1 additionally -> IDLE.
REQ-022 RUN, no step: count held, tick[i] <= 0 (tick never lasts more than one cycle).
REQ-023 start[i] in RUN SHALL restart: count <= active N, no tick that cycle.
REQ-024 stop[i] SHALL force IDLE, tick[i] <= 0; stop wins over simultaneous start and over a same-cycle terminal count.
REQ-025 N=0 in periodic mode SHALL tick on every step cycle; counting SHALL never wrap below zero.
REQ-026 Each channel SHALL hold active N plus shadow N with pending flag.
REQ-027 cfg_ready SHALL be !rst & !pending[cfg_ch], combinational.
REQ-028 Accepted write SHALL set shadow and pending for cfg_ch; cfg_ch >= CHANNELS SHALL be accepted and ignored.
REQ-029 Pending shadow SHALL move to active N (pending cleared) at that channel's next reload (REQ-021), next start, or next cycle if channel IDLE.
REQ-030 Write and reload of same channel in same cycle: reload uses old active N, write becomes pending.

Reset
REQ-031 rst SHALL dominate all inputs including cfg accept: state IDLE, count 0, tick 0, busy 0, active N = RESET_N, pending 0, prescaler count 0.
REQ-032 rst mid-operation SHALL abort any count and lose any pending write; no tick in the cycle following reset.

Configuration
REQ-033 Macro MULTI_CLKTICK_PRESCALE_EN defined: adds input pre_n [WIDTH-1:0] and shared down-counter; with en high, reaching 0 asserts pre_stb for one cycle and reloads pre_n; else pre_stb held 1.
REQ-034 Macro undefined: pre_n port and prescaler absent, pre_stb constant 1; behaviour otherwise identical.

Structure
REQ-035 Package multi_clktick_pkg SHALL hold mode enum (MODE_PERIODIC, MODE_ONESHOT) and channel state enum (ST_IDLE, ST_RUN).
REQ-036 Per-channel logic SHALL be sub-module clktick_chan, instantiated CHANNELS times by generate; top holds cfg decode and prescaler.

Verification
REQ-037 Ch0 periodic, N=3, start, en=1 -> tick[0] on every 4th cycle, first 4 cycles after start.
REQ-038 Ch1 one-shot, N=5, start -> exactly one tick[1] 6 cycles later, busy[1] then 0.
REQ-039 Ch2 running N=9, write cfg_n=2 -> cfg_ready for ch2 low until reload; period 10 then 3.
REQ-040 Same cycle start and stop on ch3 in RUN -> IDLE, no tick; N=0 periodic -> tick every cycle.
REQ-041 rst asserted mid-count with pending write -> all outputs 0, next start uses RESET_N.
REQ-042 With MULTI_CLKTICK_PRESCALE_EN, pre_n=1, ch0 N=2 -> tick[0] every 6 cycles.
